// File: rtl/spu_gbuf_resp.sv
// ============================================================================
// Module   : spu_gbuf_resp
// Purpose  : Global-buffer responder for the SPU gbuf initiator, with a host
//            load/drain port sharing a 1R1W array under SPU-first arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_gbuf_resp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int RLATENCY   = 1
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  sm_gbuf_ren,
  input  logic [ADDR_WIDTH-1:0] sm_gbuf_raddr,
  output logic [DATA_WIDTH-1:0] sm_gbuf_rdata,
  input  logic                  sm_gbuf_wen,
  input  logic [ADDR_WIDTH-1:0] sm_gbuf_waddr,
  input  logic [DATA_WIDTH-1:0] sm_gbuf_wdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  addr_err,
  input  logic                  err_clr
);

  localparam int              c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_host_gnt;
  logic                  w_host_wr;
  logic                  w_host_rd;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_wr_oor;
  logic                  w_wr_ok;
  logic                  w_rd_en;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_rd_host;
  logic                  w_rd_oor;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_err_set;

  logic                  w_tail_vld;
  logic                  w_tail_host;
  logic [DATA_WIDTH-1:0] w_tail_data;

  logic [DATA_WIDTH-1:0] r_sm_rdata;
  logic [DATA_WIDTH-1:0] r_host_rdata;
  logic                  r_host_rvalid;
  logic                  r_addr_err;

  // Host only competes for the port (read or write) it actually needs.
  assign w_host_gnt = host_we ? ~sm_gbuf_wen : ~sm_gbuf_ren;
  assign w_host_wr  = host_req &  host_we & w_host_gnt;
  assign w_host_rd  = host_req & ~host_we & w_host_gnt;

  assign w_wr_en   = sm_gbuf_wen | w_host_wr;
  assign w_wr_addr = sm_gbuf_wen ? sm_gbuf_waddr : host_addr;
  assign w_wr_data = sm_gbuf_wen ? sm_gbuf_wdata : host_wdata;
  assign w_wr_oor  = {1'b0, w_wr_addr} >= c_DEPTH;
  assign w_wr_ok   = w_wr_en & ~w_wr_oor;

  assign w_rd_en   = sm_gbuf_ren | w_host_rd;
  assign w_rd_addr = sm_gbuf_ren ? sm_gbuf_raddr : host_addr;
  assign w_rd_host = ~sm_gbuf_ren;
  assign w_rd_oor  = {1'b0, w_rd_addr} >= c_DEPTH;

  assign w_err_set = (w_wr_en & w_wr_oor) | (w_rd_en & w_rd_oor);

  // Write-first bypass: a same-cycle write to the read address wins.
  always_comb begin
    w_rd_word = '0;
    if (!w_rd_oor) begin
      if (w_wr_ok && (w_wr_addr == w_rd_addr)) begin
        w_rd_word = w_wr_data;
      end else begin
        w_rd_word = r_mem[w_rd_addr[c_IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_addr[c_IDX_W-1:0]] <= w_wr_data;
    end
  end

  // The output registers form the final pipeline stage, so only
  // RLATENCY-1 intermediate stages are needed.
  if (RLATENCY == 1) begin : g_lat1
    assign w_tail_vld  = w_rd_en;
    assign w_tail_host = w_rd_host;
    assign w_tail_data = w_rd_word;
  end else begin : g_latn
    logic [RLATENCY-2:0]   r_vld;
    logic [RLATENCY-2:0]   r_host;
    logic [DATA_WIDTH-1:0] r_data [RLATENCY-1];

    always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= '0;
        r_host <= '0;
        for (int i = 0; i < RLATENCY - 1; i++) begin
          r_data[i] <= '0;
        end
      end else begin
        r_vld[0]  <= w_rd_en;
        r_host[0] <= w_rd_host;
        r_data[0] <= w_rd_word;
        for (int i = 1; i < RLATENCY - 1; i++) begin
          r_vld[i]  <= r_vld[i-1];
          r_host[i] <= r_host[i-1];
          r_data[i] <= r_data[i-1];
        end
      end
    end

    assign w_tail_vld  = r_vld[RLATENCY-2];
    assign w_tail_host = r_host[RLATENCY-2];
    assign w_tail_data = r_data[RLATENCY-2];
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sm_rdata    <= '0;
      r_host_rdata  <= '0;
      r_host_rvalid <= 1'b0;
    end else begin
      r_host_rvalid <= w_tail_vld & w_tail_host;
      if (w_tail_vld && !w_tail_host) begin
        r_sm_rdata <= w_tail_data;
      end
      if (w_tail_vld && w_tail_host) begin
        r_host_rdata <= w_tail_data;
      end
    end
  end

  // Set has priority over clear so a new error is never lost.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else if (w_err_set) begin
      r_addr_err <= 1'b1;
    end else if (err_clr) begin
      r_addr_err <= 1'b0;
    end
  end

  assign host_gnt      = w_host_gnt;
  assign sm_gbuf_rdata = r_sm_rdata;
  assign host_rdata    = r_host_rdata;
  assign host_rvalid   = r_host_rvalid;
  assign addr_err      = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_spu_gbuf_resp.sv
// ============================================================================
// Module   : tb_spu_gbuf_resp
// Purpose  : Randomized and directed check of spu_gbuf_resp at two read
//            latencies against a timestamp-scheduled reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spu_gbuf_resp;

  localparam int c_AW = 13;
  localparam int c_DW = 32;
  localparam int c_DEPTH = 4096;
  localparam int c_NSCH = 8192;

  logic            core_clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            sm_gbuf_ren = 1'b0;
  logic [c_AW-1:0] sm_gbuf_raddr = '0;
  logic            sm_gbuf_wen = 1'b0;
  logic [c_AW-1:0] sm_gbuf_waddr = '0;
  logic [c_DW-1:0] sm_gbuf_wdata = '0;
  logic            host_req = 1'b0;
  logic            host_we = 1'b0;
  logic [c_AW-1:0] host_addr = '0;
  logic [c_DW-1:0] host_wdata = '0;
  logic            err_clr = 1'b0;

  logic [c_DW-1:0] rdata1, rdata3, hrdata1, hrdata3;
  logic            gnt1, gnt3, hrv1, hrv3, err1, err3;

  always #5 core_clk = ~core_clk;

  spu_gbuf_resp #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .DEPTH(c_DEPTH), .RLATENCY(1)) u_dut1 (
    .core_clk(core_clk), .rst_n(rst_n),
    .sm_gbuf_ren(sm_gbuf_ren), .sm_gbuf_raddr(sm_gbuf_raddr), .sm_gbuf_rdata(rdata1),
    .sm_gbuf_wen(sm_gbuf_wen), .sm_gbuf_waddr(sm_gbuf_waddr), .sm_gbuf_wdata(sm_gbuf_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(gnt1), .host_rvalid(hrv1), .host_rdata(hrdata1),
    .addr_err(err1), .err_clr(err_clr)
  );

  spu_gbuf_resp #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .DEPTH(c_DEPTH), .RLATENCY(3)) u_dut3 (
    .core_clk(core_clk), .rst_n(rst_n),
    .sm_gbuf_ren(sm_gbuf_ren), .sm_gbuf_raddr(sm_gbuf_raddr), .sm_gbuf_rdata(rdata3),
    .sm_gbuf_wen(sm_gbuf_wen), .sm_gbuf_waddr(sm_gbuf_waddr), .sm_gbuf_wdata(sm_gbuf_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(gnt3), .host_rvalid(hrv3), .host_rdata(hrdata3),
    .addr_err(err3), .err_clr(err_clr)
  );

  // Reference model: word array plus completions scheduled by absolute cycle.
  bit [c_DW-1:0] m_mem [c_DEPTH];
  bit            sch_vld  [2][c_NSCH];
  bit            sch_host [2][c_NSCH];
  bit [c_DW-1:0] sch_data [2][c_NSCH];
  int            lat [2] = '{1, 3};
  bit [c_DW-1:0] e_sm [2];
  bit [c_DW-1:0] e_hd [2];
  bit            e_hv [2];
  bit            e_err, e_err_nxt;
  bit            m_host_taken;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle();
    sm_gbuf_ren = 1'b0; sm_gbuf_wen = 1'b0; host_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_outputs();
    check("L1 sm_rdata",    rdata1,  e_sm[0]);
    check("L1 host_rdata",  hrdata1, e_hd[0]);
    check("L1 host_rvalid", hrv1,    e_hv[0]);
    check("L1 addr_err",    err1,    e_err);
    check("L3 sm_rdata",    rdata3,  e_sm[1]);
    check("L3 host_rdata",  hrdata3, e_hd[1]);
    check("L3 host_rvalid", hrv3,    e_hv[1]);
    check("L3 addr_err",    err3,    e_err);
  endtask

  // One clock cycle: inputs are already driven in the low phase.
  task automatic tick();
    logic [c_AW-1:0] wa, ra;
    logic [c_DW-1:0] wd, rv;
    bit g, take, wr, rd, rh;
    #1;
    g = host_we ? !sm_gbuf_wen : !sm_gbuf_ren;
    check("L1 host_gnt", gnt1, g);
    check("L3 host_gnt", gnt3, g);
    take = host_req && g;
    m_host_taken = take;
    wr = 1'b0; wa = '0; wd = '0;
    if (sm_gbuf_wen) begin
      wr = 1'b1; wa = sm_gbuf_waddr; wd = sm_gbuf_wdata;
    end else if (take && host_we) begin
      wr = 1'b1; wa = host_addr; wd = host_wdata;
    end
    rd = 1'b0; ra = '0; rh = 1'b0;
    if (sm_gbuf_ren) begin
      rd = 1'b1; ra = sm_gbuf_raddr;
    end else if (take && !host_we) begin
      rd = 1'b1; ra = host_addr; rh = 1'b1;
    end
    rv = '0;
    if (rd && ra < c_DEPTH) rv = (wr && wa == ra) ? wd : m_mem[ra[11:0]];
    if (wr && wa < c_DEPTH) m_mem[wa[11:0]] = wd;
    e_err_nxt = ((wr && wa >= c_DEPTH) || (rd && ra >= c_DEPTH)) ? 1'b1 : (err_clr ? 1'b0 : e_err);
    if (rd) begin
      for (int k = 0; k < 2; k++) begin
        sch_vld[k][cyc + lat[k]]  = 1'b1;
        sch_host[k][cyc + lat[k]] = rh;
        sch_data[k][cyc + lat[k]] = rv;
      end
    end
    @(posedge core_clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      e_hv[k] = 1'b0;
      if (sch_vld[k][cyc]) begin
        if (sch_host[k][cyc]) begin
          e_hd[k] = sch_data[k][cyc];
          e_hv[k] = 1'b1;
        end else begin
          e_sm[k] = sch_data[k][cyc];
        end
      end
    end
    e_err = e_err_nxt;
    check_outputs();
    @(negedge core_clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = cyc + 1; i < c_NSCH; i++) sch_vld[k][i] = 1'b0;
      e_sm[k] = '0; e_hd[k] = '0; e_hv[k] = 1'b0;
    end
    e_err = 1'b0;
    check_outputs();
    repeat (2) begin
      @(posedge core_clk);
      cyc++;
    end
    @(negedge core_clk);
    rst_n = 1'b1;
  endtask

  task automatic spu_wr(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
    sm_gbuf_wen = 1'b1; sm_gbuf_waddr = a; sm_gbuf_wdata = d;
  endtask

  task automatic spu_rd(input logic [c_AW-1:0] a);
    sm_gbuf_ren = 1'b1; sm_gbuf_raddr = a;
  endtask

  function automatic logic [c_AW-1:0] rand_addr();
    if ($urandom_range(15) == 0) return c_AW'(13'h1000 + $urandom_range(255));
    return c_AW'($urandom_range(511));
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    // Fill the working region so every later read has a known value.
    for (int a = 0; a < 512; a++) begin
      idle(); spu_wr(c_AW'(a), $urandom); tick();
    end

    // Write then read back, held while idle.
    idle(); spu_wr(13'h010, 32'hA5A5_0001); tick();
    idle(); spu_rd(13'h010); tick();
    idle(); repeat (5) tick();
    check("tp held L1", rdata1, 32'hA5A5_0001);
    check("tp held L3", rdata3, 32'hA5A5_0001);

    // Same-cycle read and write: write-first.
    idle(); spu_wr(13'h020, 32'h0000_FFFF); tick();
    idle(); spu_wr(13'h020, 32'h0000_1234); spu_rd(13'h020); tick();
    idle(); repeat (3) tick();
    check("wfirst L1", rdata1, 32'h0000_1234);
    check("wfirst L3", rdata3, 32'h0000_1234);

    // Host read blocked by SPU read, then granted.
    idle(); spu_rd(13'h031); host_req = 1'b1; host_we = 1'b0; host_addr = 13'h030; tick();
    sm_gbuf_ren = 1'b0; tick();
    idle(); repeat (4) tick();

    // Host write concurrent with SPU read, then read back.
    idle(); spu_rd(13'h041); host_req = 1'b1; host_we = 1'b1; host_addr = 13'h040;
    host_wdata = 32'h0000_DEAD; tick();
    idle(); spu_rd(13'h040); tick();
    idle(); repeat (3) tick();
    check("host wr L1", rdata1, 32'h0000_DEAD);
    check("host wr L3", rdata3, 32'h0000_DEAD);

    // Back-to-back SPU read stream.
    for (int a = 'h100; a < 'h110; a++) begin
      idle(); spu_rd(c_AW'(a)); tick();
    end
    idle(); repeat (4) tick();

    // Out-of-range access, error flag set/clear, aliasing word untouched.
    idle(); spu_wr(13'h1000, 32'hBAD0_BAD0); tick();
    check("oor err L1", err1, 1'b1);
    check("oor err L3", err3, 1'b1);
    idle(); spu_rd(13'h1000); tick();
    idle(); spu_rd(13'h0000); tick();
    idle(); repeat (3) tick();
    idle(); err_clr = 1'b1; tick();
    idle(); tick();

    // Randomized mixed traffic with a compliant host that holds until granted.
    for (int n = 0; n < 1500; n++) begin
      sm_gbuf_ren = ($urandom_range(1) == 1);
      sm_gbuf_raddr = rand_addr();
      sm_gbuf_wen = ($urandom_range(2) == 0);
      sm_gbuf_waddr = rand_addr();
      sm_gbuf_wdata = $urandom;
      err_clr = ($urandom_range(7) == 0);
      if (!host_req || m_host_taken) begin
        host_req = ($urandom_range(1) == 1);
        host_we = ($urandom_range(1) == 1);
        host_addr = rand_addr();
        host_wdata = $urandom;
      end
      tick();
    end
    idle(); repeat (4) tick();

    // Reset with reads in flight: nothing completes afterwards.
    idle(); spu_rd(13'h011); tick();
    idle(); host_req = 1'b1; host_we = 1'b0; host_addr = 13'h012; tick();
    do_reset();
    idle(); repeat (5) tick();
    idle(); spu_rd(13'h010); tick();
    idle(); repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
